// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the E-stage multiply/divide unit: md_op codes,
// FSM states and the SPECIAL func codes used by decode/hazard logic.
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_countdown.sv
// Loadable down-counter that tracks the remaining latency of a mult/div.
// Saturates at zero; last flags the final busy cycle.
module md_countdown #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] value,
    output logic          last,
    output logic          nonzero
);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - CW'(1);
        end
    end

    assign last    = (count_reg == CW'(1));
    assign nonzero = (count_reg != '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, runs a fixed-latency
// mult/div and requests a D-stage stall while a result is outstanding.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    md_state_e   state_reg;
    logic        busy_reg;
    logic [31:0] hi_reg, lo_reg;
    logic [31:0] a_reg, b_reg;
    logic [2:0]  op_reg;

    logic          cnt_load, cnt_last, cnt_nonzero;
    logic [CW-1:0] cnt_value;

    assign cnt_load  = start && is_long_op(md_op) && (state_reg == ST_IDLE);
    assign cnt_value = ((md_op == MD_MULT) || (md_op == MD_MULTU)) ? CW'(MULT_CYCLES)
                                                                   : CW'(DIV_CYCLES);

    md_countdown #(.CW(CW)) u_countdown (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .value   (cnt_value),
        .last    (cnt_last),
        .nonzero (cnt_nonzero)
    );

    // Result datapath works off the latched operands, so it is stable for the whole busy window.
    logic [63:0] prod_s, prod_u;
    logic [32:0] quot_s, rem_s;
    logic [31:0] quot_u, rem_u;
    logic [31:0] res_hi, res_lo;
    logic        res_valid;

    always_comb begin
        prod_s = 64'($signed({{32{a_reg[31]}}, a_reg}) * $signed({{32{b_reg[31]}}, b_reg}));
        prod_u = {32'b0, a_reg} * {32'b0, b_reg};
        // 33-bit signed divide keeps 0x80000000 / -1 from overflowing; the low word is the answer.
        quot_s = 33'($signed({a_reg[31], a_reg}) / $signed({b_reg[31], b_reg}));
        rem_s  = 33'($signed({a_reg[31], a_reg}) % $signed({b_reg[31], b_reg}));
        quot_u = a_reg / b_reg;
        rem_u  = a_reg % b_reg;
        res_hi    = hi_reg;
        res_lo    = lo_reg;
        res_valid = 1'b0;
        case (op_reg)
            MD_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; res_valid = 1'b1; end
            MD_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; res_valid = 1'b1; end
            MD_DIV:   begin res_hi = rem_s[31:0];   res_lo = quot_s[31:0]; res_valid = (b_reg != 32'd0); end
            MD_DIVU:  begin res_hi = rem_u;         res_lo = quot_u;       res_valid = (b_reg != 32'd0); end
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        case (md_op)
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                a_reg     <= rs_val;
                                b_reg     <= rt_val;
                                op_reg    <= md_op;
                                state_reg <= ST_BUSY;
                                busy_reg  <= 1'b1;
                            end
                            MD_MTHI: hi_reg <= rs_val;
                            MD_MTLO: lo_reg <= rs_val;
                            default: ;
                        endcase
                    end
                end
                ST_BUSY: begin
                    // nonzero guard only matters if the counter were ever lost; normal exit is on last.
                    if (cnt_last || !cnt_nonzero) begin
                        if (res_valid) begin
                            hi_reg <= res_hi;
                            lo_reg <= res_lo;
                        end
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign stall_md = md_use_D && (busy_reg || (start && is_long_op(md_op)));

endmodule
